// File: rtl/axis_pipe_slice.sv
// AXI-Stream pipeline of STAGES registered skid slices; every output comes from a flop.
// Optional completed-packet counter on PKT_CNT, enabled by defining AXIS_PIPE_PKTCNT_EN.
module axis_pipe_slice #(
  parameter int DATAW  = 32,
  parameter int IDW    = 4,
  parameter int USERW  = 4,
  parameter int DESTW  = 4,
  parameter int STAGES = 2,
  localparam int OCCW  = $clog2(2*STAGES+1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [DATAW-1:0]  AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [IDW-1:0]    AXIS_S_TID,
  input  logic [USERW-1:0]  AXIS_S_TUSER,
  input  logic [DESTW-1:0]  AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [DATAW-1:0]  AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [IDW-1:0]    AXIS_M_TID,
  output logic [USERW-1:0]  AXIS_M_TUSER,
  output logic [DESTW-1:0]  AXIS_M_TDEST,
`ifdef AXIS_PIPE_PKTCNT_EN
  output logic [15:0]       PKT_CNT,
`endif
  output logic [OCCW-1:0]   OCC
);

  localparam int PW = DATAW + 1 + IDW + USERW + DESTW;
  localparam logic [OCCW-1:0] OCC_MAX = OCCW'(2*STAGES);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} slice_state_t;

  // Index k is the slave side of slice k; index STAGES is the block's master side.
  logic [STAGES:0] chain_valid;
  logic [STAGES:0] chain_ready;
  logic [PW-1:0]   chain_data [STAGES+1];

  assign chain_valid[0]      = AXIS_S_TVALID;
  assign chain_data[0]       = {AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TUSER, AXIS_S_TDEST};
  assign chain_ready[STAGES] = AXIS_M_TREADY;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    slice_state_t  state_q, state_d;
    logic          ready_q;
    logic [PW-1:0] main_q, skid_q;
    logic          accept, take;
    logic          load_main, load_skid, skid_to_main;

    assign accept = chain_valid[k] & ready_q;
    assign take   = (state_q != S_EMPTY) & chain_ready[k+1];

    always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !take) begin
            load_skid = 1'b1;
            state_d   = S_TWO;
          end else if (take && !accept) begin
            state_d   = S_EMPTY;
          end else if (accept && take) begin
            load_main = 1'b1;
          end
        end
        S_TWO: begin
          if (take) begin
            skid_to_main = 1'b1;
            state_d      = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Ready is registered from the next state so it is low exactly while the skid holds a beat.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= S_EMPTY;
        ready_q <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != S_TWO);
        if (load_main)
          main_q <= chain_data[k];
        else if (skid_to_main)
          main_q <= skid_q;
        if (load_skid)
          skid_q <= chain_data[k];
      end
    end

    assign chain_valid[k+1] = (state_q != S_EMPTY);
    assign chain_ready[k]   = ready_q;
    assign chain_data[k+1]  = main_q;
  end

  assign AXIS_S_TREADY = chain_ready[0];
  assign AXIS_M_TVALID = chain_valid[STAGES];
  assign {AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST} = chain_data[STAGES];

  logic s_xfer, m_xfer;
  logic [OCCW-1:0] occ_q;

  assign s_xfer = AXIS_S_TVALID & AXIS_S_TREADY;
  assign m_xfer = AXIS_M_TVALID & AXIS_M_TREADY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      occ_q <= '0;
    else if (s_xfer && !m_xfer && occ_q != OCC_MAX)
      occ_q <= occ_q + 1'b1;
    else if (m_xfer && !s_xfer && occ_q != '0)
      occ_q <= occ_q - 1'b1;
  end

  assign OCC = occ_q;

`ifdef AXIS_PIPE_PKTCNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      pkt_cnt_q <= '0;
    else if (m_xfer && AXIS_M_TLAST)
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign PKT_CNT = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Self-checking bench for axis_pipe_slice: directed latency/streaming/capacity/reset cases
// plus randomized valid/ready stress against a queue-based scoreboard.
module tb_axis_pipe_slice;

  localparam int STAGES   = 2;
  localparam int OCCW     = $clog2(2*STAGES+1);
  localparam int PW       = 32 + 1 + 4 + 4 + 4;
  localparam int LAST_BIT = 12;

  logic            CLK;
  logic            RST_N;
  logic            AXIS_S_TVALID;
  logic            AXIS_S_TREADY;
  logic [31:0]     AXIS_S_TDATA;
  logic            AXIS_S_TLAST;
  logic [3:0]      AXIS_S_TID;
  logic [3:0]      AXIS_S_TUSER;
  logic [3:0]      AXIS_S_TDEST;
  logic            AXIS_M_TVALID;
  logic            AXIS_M_TREADY;
  logic [31:0]     AXIS_M_TDATA;
  logic            AXIS_M_TLAST;
  logic [3:0]      AXIS_M_TID;
  logic [3:0]      AXIS_M_TUSER;
  logic [3:0]      AXIS_M_TDEST;
  logic [OCCW-1:0] OCC;
`ifdef AXIS_PIPE_PKTCNT_EN
  logic [15:0]     PKT_CNT;
  logic [15:0]     pkt_exp;
`endif

  logic [PW-1:0] m_payload;
  assign m_payload = {AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST};

  axis_pipe_slice #(.DATAW(32), .IDW(4), .USERW(4), .DESTW(4), .STAGES(STAGES)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TID(AXIS_S_TID),
    .AXIS_S_TUSER(AXIS_S_TUSER), .AXIS_S_TDEST(AXIS_S_TDEST),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TID(AXIS_M_TID),
    .AXIS_M_TUSER(AXIS_M_TUSER), .AXIS_M_TDEST(AXIS_M_TDEST),
`ifdef AXIS_PIPE_PKTCNT_EN
    .PKT_CNT(PKT_CNT),
`endif
    .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            tests = 0;
  int            fails = 0;
  logic [PW-1:0] exp_q[$];
  bit            last_s_x, last_m_x;
  bit            prev_stalled = 1'b0;
  logic [PW-1:0] prev_pl = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkBeat(input logic [31:0] d, input bit l,
                                           input logic [3:0] id, input logic [3:0] u,
                                           input logic [3:0] de);
    return {d, l, id, u, de};
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, scores the coming rising edge,
  // and returns at the next falling edge after checking occupancy against the model.
  task automatic applyStimulus(input bit sv, input logic [PW-1:0] pl, input bit mr);
    logic [PW-1:0] m_pl;
    if (prev_stalled) begin
      checkOutput("stall_valid", AXIS_M_TVALID, 1'b1);
      checkOutput("stall_payload", m_payload, prev_pl);
    end
    AXIS_S_TVALID = sv;
    {AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TUSER, AXIS_S_TDEST} = pl;
    AXIS_M_TREADY = mr;
    m_pl     = m_payload;
    last_s_x = sv && AXIS_S_TREADY;
    last_m_x = AXIS_M_TVALID && mr;
    if (last_m_x) begin
      checkOutput("m_payload", m_pl, (exp_q.size() > 0) ? exp_q[0] : ~m_pl);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
`ifdef AXIS_PIPE_PKTCNT_EN
      if (m_pl[LAST_BIT]) pkt_exp = pkt_exp + 16'd1;
`endif
    end
    if (last_s_x) exp_q.push_back(pl);
    prev_stalled = AXIS_M_TVALID && !mr;
    prev_pl      = m_pl;
    @(negedge CLK);
    checkOutput("occ", OCC, exp_q.size());
    if (exp_q.size() >= 2*STAGES) checkOutput("full_ready", AXIS_S_TREADY, 1'b0);
`ifdef AXIS_PIPE_PKTCNT_EN
    checkOutput("pkt_cnt", PKT_CNT, pkt_exp);
`endif
  endtask

  task automatic drainPipe(input string tag);
    for (int c = 0; c < 4*STAGES + 10 && exp_q.size() > 0; c++)
      applyStimulus(1'b0, '0, 1'b1);
    checkOutput(tag, exp_q.size(), 0);
  endtask

  task automatic sendBeat(input logic [PW-1:0] pl);
    for (int t = 0; t < 4*STAGES + 4; t++) begin
      applyStimulus(1'b1, pl, 1'b1);
      if (last_s_x) break;
    end
    checkOutput("send_accept", last_s_x, 1'b1);
  endtask

  initial begin
    int lat, sent, got, acc;
    RST_N = 1'b0;
    AXIS_S_TVALID = 1'b0;
    {AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TUSER, AXIS_S_TDEST} = '0;
    AXIS_M_TREADY = 1'b0;
`ifdef AXIS_PIPE_PKTCNT_EN
    pkt_exp = '0;
`endif
    repeat (3) @(negedge CLK);

    // Reset state and ready rising on the first edge after release
    checkOutput("rst_m_valid", AXIS_M_TVALID, 1'b0);
    checkOutput("rst_s_ready", AXIS_S_TREADY, 1'b0);
    checkOutput("rst_occ", OCC, 0);
    checkOutput("rst_m_payload", m_payload, 0);
`ifdef AXIS_PIPE_PKTCNT_EN
    checkOutput("rst_pkt_cnt", PKT_CNT, 0);
`endif
    RST_N = 1'b1;
    checkOutput("rel_ready_before_edge", AXIS_S_TREADY, 1'b0);
    @(negedge CLK);
    checkOutput("rel_ready_after_edge", AXIS_S_TREADY, 1'b1);

    // Latency of a single beat through an empty pipe
    applyStimulus(1'b1, mkBeat(32'hA5A5A5A5, 1'b1, 4'd3, 4'd0, 4'd0), 1'b1);
    lat = 1;
    while (!AXIS_M_TVALID && lat < 20) begin
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    checkOutput("latency", lat, STAGES);
    checkOutput("lat_tdata", AXIS_M_TDATA, 32'hA5A5A5A5);
    checkOutput("lat_tid", AXIS_M_TID, 4'd3);
    checkOutput("lat_tlast", AXIS_M_TLAST, 1'b1);
    drainPipe("lat_drain");

    // Back-to-back streaming at full rate
    sent = 0;
    got  = 0;
    for (int c = 0; c < 200 && got < 64; c++) begin
      if (got > 0 && got < 64) checkOutput("stream_bubble", AXIS_M_TVALID, 1'b1);
      if (got > 0 && sent < 64) checkOutput("stream_occ", OCC, STAGES);
      if (sent < 64) checkOutput("stream_ready", AXIS_S_TREADY, 1'b1);
      applyStimulus(sent < 64, mkBeat(32'h1000_0000 + sent, sent == 63, 4'(sent), 4'(sent >> 4), 4'd5), 1'b1);
      if (last_s_x) sent++;
      if (last_m_x) got++;
    end
    checkOutput("stream_count", got, 64);

    // Full backpressure: capacity, then release and drain in order
    acc = 0;
    for (int c = 0; c < 4*STAGES + 4; c++) begin
      applyStimulus(1'b1, mkBeat(32'h2000_0000 + acc, 1'b0, 4'(acc), 4'd1, 4'd2), 1'b0);
      if (last_s_x) acc++;
    end
    checkOutput("cap_accepted", acc, 2*STAGES);
    checkOutput("cap_ready", AXIS_S_TREADY, 1'b0);
    checkOutput("cap_occ", OCC, 2*STAGES);
    for (int c = 0; c < 40 && acc < 2*STAGES + 8; c++) begin
      applyStimulus(1'b1, mkBeat(32'h2000_0000 + acc, acc == 2*STAGES + 7, 4'(acc), 4'd1, 4'd2), 1'b1);
      if (last_s_x) acc++;
    end
    checkOutput("cap_tail_accepted", acc, 2*STAGES + 8);
    drainPipe("cap_drain");

    // Random valid/ready stress
    acc = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), {32'($urandom), 13'($urandom)}, 1'($urandom_range(0, 1)));
      if (last_s_x) acc++;
    end
    checkOutput("stress_beats", acc, 10000);
    drainPipe("stress_drain");

    // Reset with a partial packet held
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      applyStimulus(1'b1, mkBeat(32'h3000_0000 + acc, 1'b0, 4'd7, 4'd0, 4'd1), 1'b0);
      if (last_s_x) acc++;
    end
    checkOutput("mid_held", OCC, 4);
    AXIS_S_TVALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", AXIS_M_TVALID, 1'b0);
    checkOutput("mid_rst_s_ready", AXIS_S_TREADY, 1'b0);
    checkOutput("mid_rst_occ", OCC, 0);
    exp_q.delete();
    prev_stalled = 1'b0;
`ifdef AXIS_PIPE_PKTCNT_EN
    pkt_exp = '0;
`endif
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    checkOutput("mid_rel_ready_before", AXIS_S_TREADY, 1'b0);
    @(negedge CLK);
    checkOutput("mid_rel_ready_after", AXIS_S_TREADY, 1'b1);
    sendBeat(mkBeat(32'h4000_0001, 1'b0, 4'd2, 4'd3, 4'd4));
    drainPipe("mid_drain");

`ifdef AXIS_PIPE_PKTCNT_EN
    // Packet counter: three 5-beat packets, then wrap from 0xFFFF
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 5; b++)
        sendBeat(mkBeat(32'h5000_0000 + 32'(p*5 + b), b == 4, 4'(p), 4'd0, 4'd0));
    drainPipe("pkt_drain");
    checkOutput("pkt_cnt_three", PKT_CNT, 16'd3);
    dut.pkt_cnt_q = 16'hFFFF;
    pkt_exp = 16'hFFFF;
    sendBeat(mkBeat(32'h6000_0000, 1'b1, 4'd1, 4'd0, 4'd0));
    drainPipe("wrap_drain");
    checkOutput("pkt_cnt_wrap", PKT_CNT, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_pipe_slice.md
# axis_pipe_slice

Parametrised, fully registered AXI-Stream pipeline of `STAGES` skid-buffer slices. It breaks long timing paths between AXIS producers and consumers in the MVM datapath. Every output, including `AXIS_S_TREADY`, comes from a flop, and throughput stays at one beat per cycle under arbitrary backpressure. No beat is dropped or duplicated. It replaces single-flop passthrough stages, which do not honour the ready/valid contract.

## Interface
Parameters:
- `DATAW`, 32, TDATA width
- `IDW`, 4, TID width
- `USERW`, 4, TUSER width
- `DESTW`, 4, TDEST width
- `STAGES`, 2, number of cascaded skid slices, legal range 1..8
- `OCCW`, `$clog2(2*STAGES+1)`, derived local parameter, width of `OCC`

Ports:
- `CLK` in 1: single clock, all logic rising-edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `AXIS_S_TVALID` in 1: slave valid.
- `AXIS_S_TREADY` out 1: slave ready, registered.
- `AXIS_S_TDATA` in `DATAW`: slave data.
- `AXIS_S_TLAST` in 1: slave last.
- `AXIS_S_TID` in `IDW`: slave ID.
- `AXIS_S_TUSER` in `USERW`: slave user.
- `AXIS_S_TDEST` in `DESTW`: slave destination.
- `AXIS_M_TVALID` out 1: master valid, registered.
- `AXIS_M_TREADY` in 1: master ready.
- `AXIS_M_TDATA` out `DATAW`: master data.
- `AXIS_M_TLAST` out 1: master last.
- `AXIS_M_TID` out `IDW`: master ID.
- `AXIS_M_TUSER` out `USERW`: master user.
- `AXIS_M_TDEST` out `DESTW`: master destination.
- `OCC` out `OCCW`: beats currently held, 0..2*STAGES.
- `PKT_CNT` out 16: completed-packet count. Present only with `AXIS_PIPE_PKTCNT_EN`.

## Operation
- **Payload.** The payload is {TDATA, TLAST, TID, TUSER, TDEST}. It is carried as one word, in order, unmodified.
- **Slice registers.** Each slice holds a main register (feeds downstream) and a skid register (catches the beat accepted while downstream stalls).
- **Slice states:**
  - `EMPTY`: main invalid. Upstream accept goes to main, then `ONE`.
  - `ONE`: main valid, skid empty.
    - Accept without downstream take: beat goes to skid, then `TWO`.
    - Take without accept: go to `EMPTY`.
    - Accept and take together: main reloads, stay in `ONE`.
  - `TWO`: main and skid both valid, upstream ready low.
    - Downstream take: skid moves to main, then `ONE`.
- **Slice ready.** Slice ready = NOT skid-valid, as a flop.
- **Slice valid.** Slice valid = main-valid.
- **Chaining.** Slice k's master side drives slice k+1's slave side.
- **Handshake rules:**
  - A transfer happens only on a cycle with VALID and READY both high.
  - Payload and VALID at the master are stable while VALID=1 and READY=0.
  - The block never depends on `AXIS_M_TREADY` arriving before `AXIS_M_TVALID`, and vice versa.
- **`OCC` counter:**
  - Increments on a slave-side transfer.
  - Decrements on a master-side transfer.
  - Unchanged when both transfers occur in the same cycle.
  - Never exceeds 2*STAGES or wraps below 0.
- **Reset:**
  - `AXIS_M_TVALID`=0, `AXIS_S_TREADY`=0, all master payload outputs=0, `OCC`=0, `PKT_CNT`=0, all slices `EMPTY`.
  - `AXIS_S_TREADY` rises on the first clock edge after `RST_N` deasserts.
- **Reset mid-operation.** Asserting reset mid-operation discards all held beats immediately, including mid-packet; there is no partial-packet recovery.

## Timing
- **Latency.** Latency is `STAGES` cycles, measured from the slave transfer edge to `AXIS_M_TVALID` high, with the pipe empty.
- **Throughput.** Sustained throughput is 1 beat/cycle while `AXIS_M_TREADY`=1.
- **Capacity.** Capacity is 2*STAGES beats with `AXIS_M_TREADY` held low.
  - `AXIS_S_TREADY` falls the cycle after the input slice's skid fills.
  - Beats accepted on the cycle ready falls are retained.
- **Backpressure release.** After `AXIS_M_TREADY` rises, `AXIS_S_TREADY` recovers within `STAGES` cycles.
- **Combinational paths.** There is no combinational path from any input to any output.

## Configuration
- **Macro:** `AXIS_PIPE_PKTCNT_EN`.
- **Defined:**
  - Adds port `PKT_CNT` (16-bit).
  - The count increments on each master-side transfer with TLAST=1.
  - It wraps 0xFFFF→0x0000.
  - It resets to 0.
- **Undefined:** the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- **Latency, STAGES=2:** send single beat TDATA=0xA5A5A5A5, TID=3, TLAST=1, with M_TREADY=1 → master valid exactly 2 cycles later, all fields match, `OCC` 1→0.
- **Streaming:** send 64 back-to-back beats (incrementing data) with M_TREADY=1 → 64 beats out in order, no bubbles after the first, `OCC` constant at 2 in steady state.
- **Full backpressure, STAGES=3:** hold M_TREADY=0 and keep S_TVALID=1 → exactly 6 beats accepted, S_TREADY=0, `OCC`=6. Then raise M_TREADY → all 6 beats, then the remaining input, drain in order.
- **Random stress:** apply random S_TVALID/M_TREADY at 50% for 10k beats → the scoreboard sees no loss, duplication or reordering, master payload is stable while stalled, `OCC` always equals accepted minus delivered.
- **Reset mid-packet:** assert RST_N low with 4 beats held → M_TVALID, S_TREADY and `OCC` are 0 asynchronously. After release, S_TREADY=1 next edge and a new beat passes cleanly.
- **Packet count (`AXIS_PIPE_PKTCNT_EN` defined):** send 3 packets of 5 beats → `PKT_CNT`=3. Preload 0xFFFF and send one more packet → `PKT_CNT`=0.
